// File: rtl/cordic_iter_ctrl.sv
// Sequencer for the CORDIC float datapath: per job, one operand load followed by
// N_ITER micro-rotation steps, each step waiting for a datapath ack.
module cordic_iter_ctrl #(
  parameter int N_ITER = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              mode,
  input  logic              z_sign,
  input  logic              y_sign,
  input  logic              abort,
  output logic              dp_load,
  output logic              dp_step,
  input  logic              dp_ack,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0] shift_amt,
  output logic              dir,
  output logic [ADDR_W-1:0] iter_idx,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready
);

  // state | meaning
  // IDLE  | no job, start_ready high
  // LOAD  | dp_load pulse, datapath loads x/y/z
  // STEP  | dp_step pulse, dir taken live from the sign bits
  // WAIT  | step outputs held until dp_ack
  // DONE  | out_valid held until out_ready
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_WAIT, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ITER - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] iter_idx_q, iter_idx_d;
  logic              mode_q, mode_d;
  logic              dir_q, dir_d;
  logic              start_ready_q, start_ready_d;
  logic              busy_q, busy_d;
  logic              dp_load_q, dp_load_d;
  logic              dp_step_q, dp_step_d;
  logic              out_valid_q, out_valid_d;
  logic              dir_live;

  // Rotation drives z toward 0, vectoring drives y toward 0.
  assign dir_live = mode_q ? y_sign : ~z_sign;

  always_comb begin
    state_d    = state_q;
    iter_idx_d = iter_idx_q;
    mode_d     = mode_q;
    dir_d      = dir_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          mode_d     = mode;
          iter_idx_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = abort ? S_IDLE : S_STEP;
      end
      S_STEP: begin
        if (abort) begin
          state_d    = S_IDLE;
          iter_idx_d = '0;
        end else begin
          dir_d   = dir_live;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d    = S_IDLE;
          iter_idx_d = '0;
        end else if (dp_ack) begin
          if (iter_idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            iter_idx_d = iter_idx_q + ADDR_W'(1);
            state_d    = S_STEP;
          end
        end
      end
      S_DONE: begin
        if (abort || out_ready) begin
          state_d    = S_IDLE;
          iter_idx_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        iter_idx_d = '0;
      end
    endcase

    start_ready_d = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    dp_load_d     = (state_d == S_LOAD);
    dp_step_d     = (state_d == S_STEP);
    out_valid_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      iter_idx_q    <= '0;
      mode_q        <= 1'b0;
      dir_q         <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      dp_load_q     <= 1'b0;
      dp_step_q     <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      iter_idx_q    <= iter_idx_d;
      mode_q        <= mode_d;
      dir_q         <= dir_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
      dp_load_q     <= dp_load_d;
      dp_step_q     <= dp_step_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // dir is live only while stepping so the datapath sees the current sign.
  assign dir         = (state_q == S_STEP) ? dir_live : dir_q;
  assign rom_addr    = iter_idx_q;
  assign shift_amt   = iter_idx_q;
  assign iter_idx    = iter_idx_q;
  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign dp_load     = dp_load_q;
  assign dp_step     = dp_step_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: acts as job source, datapath and sink, with a queue
// of expected (rom_addr, dir) per step filled at job start.
module tb_cordic_iter_ctrl;
  localparam int N  = 16;
  localparam int AW = 4;

  typedef struct packed {logic [AW-1:0] addr; logic dir;} exp_t;
  typedef enum int {P_IDLE, P_LOAD, P_STEP, P_WAIT, P_DONE} ph_t;

  logic clk = 1'b0, rst = 1'b1;
  logic start_valid = 1'b0, mode = 1'b0, z_sign = 1'b0, y_sign = 1'b0;
  logic abort = 1'b0, dp_ack = 1'b0, out_ready = 1'b0;
  logic start_ready, dp_load, dp_step, dir, busy, out_valid;
  logic [AW-1:0] rom_addr, shift_amt, iter_idx;

  int checks = 0, errors = 0, cyc = 0;
  exp_t exp_q[$];

  cordic_iter_ctrl #(.N_ITER(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .mode(mode), .z_sign(z_sign), .y_sign(y_sign), .abort(abort),
    .dp_load(dp_load), .dp_step(dp_step), .dp_ack(dp_ack),
    .rom_addr(rom_addr), .shift_amt(shift_amt), .dir(dir), .iter_idx(iter_idx),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // pat selects the primary sign (z for rotation, y for vectoring): 0 = all 0,
  // 1 = toggling, 2 = random. The other sign is random so a mode mix-up shows.
  task automatic run_job(input logic m, input int pat, input int ack_dly, input bit ack_in_step,
                         input int abort_iter, input int ready_dly, input bit abort_at_start);
    logic zs[N];
    logic ys[N];
    logic p;
    exp_t e, held;
    ph_t ph;
    int k, wcnt, rcnt, t_acc, budget;
    bit finished;
    logic [4:0] exp_vec;
    for (int i = 0; i < N; i++) begin
      if (pat == 0) p = 1'b0;
      else if (pat == 1) p = 1'(i % 2);
      else p = 1'($urandom_range(0, 1));
      if (m) begin ys[i] = p; zs[i] = 1'($urandom_range(0, 1)); end
      else begin zs[i] = p; ys[i] = 1'($urandom_range(0, 1)); end
      e.addr = AW'(i);
      e.dir  = m ? ys[i] : ~zs[i];
      exp_q.push_back(e);
    end
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: start_ready=%b required 1", start_ready);
    end
    start_valid = 1'b1; mode = m; abort = abort_at_start;
    t_acc = cyc;
    tick();
    start_valid = 1'b0; mode = ~m; abort = 1'b0;
    ph = P_LOAD; k = 0; wcnt = 0; rcnt = 0; finished = 0; held = '0;
    budget = 40 + N * (ack_dly + 2) + ready_dly;
    for (int c = 0; c < budget && !finished; c++) begin
      if (ph == P_STEP) begin z_sign = zs[k]; y_sign = ys[k]; end
      else begin z_sign = ~zs[k]; y_sign = ~ys[k]; end
      dp_ack = 1'b0; abort = 1'b0; out_ready = 1'b0;
      #1;
      exp_vec = {ph == P_LOAD, ph == P_STEP, ph == P_DONE, ph != P_IDLE, ph == P_IDLE};
      checks++;
      if ({dp_load, dp_step, out_valid, busy, start_ready} !== exp_vec) begin
        errors++;
        $display("FAIL ctrl_vec cycle %0d phase %s: load/step/valid/busy/ready=%b required %b",
                 cyc, ph.name(), {dp_load, dp_step, out_valid, busy, start_ready}, exp_vec);
      end
      case (ph)
        P_LOAD: ph = P_STEP;
        P_STEP: begin
          held = exp_q.pop_front();
          checks++;
          if ({rom_addr, shift_amt, iter_idx, dir} !== {held.addr, held.addr, held.addr, held.dir}) begin
            errors++;
            $display("FAIL step_out k=%0d: addr/shift/idx/dir=%0d/%0d/%0d/%b required %0d/%0d/%0d/%b",
                     k, rom_addr, shift_amt, iter_idx, dir, held.addr, held.addr, held.addr, held.dir);
          end
          if (ack_dly == 1 && !ack_in_step) begin
            checks++;
            if (cyc != t_acc + 2 + 2 * k) begin
              errors++;
              $display("FAIL step_time k=%0d: cycle %0d required %0d", k, cyc, t_acc + 2 + 2 * k);
            end
          end
          wcnt = 0;
          dp_ack = ack_in_step;
          ph = P_WAIT;
        end
        P_WAIT: begin
          wcnt++;
          checks++;
          if ({rom_addr, shift_amt, iter_idx, dir} !== {held.addr, held.addr, held.addr, held.dir}) begin
            errors++;
            $display("FAIL wait_hold k=%0d: addr/shift/idx/dir=%0d/%0d/%0d/%b required %0d/%0d/%0d/%b",
                     k, rom_addr, shift_amt, iter_idx, dir, held.addr, held.addr, held.addr, held.dir);
          end
          if (wcnt == ack_dly) begin
            dp_ack = 1'b1;
            if (k == abort_iter) begin abort = 1'b1; ph = P_IDLE; end
            else if (k == N - 1) ph = P_DONE;
            else begin k++; ph = P_STEP; end
          end
        end
        P_DONE: begin
          checks++;
          if (iter_idx !== AW'(N - 1)) begin
            errors++;
            $display("FAIL done_idx: iter_idx=%0d required %0d", iter_idx, N - 1);
          end
          if (rcnt == 0 && ack_dly == 1 && !ack_in_step) begin
            checks++;
            if (cyc != t_acc + 2 + 2 * N) begin
              errors++;
              $display("FAIL done_time: cycle %0d required %0d", cyc, t_acc + 2 + 2 * N);
            end
          end
          rcnt++;
          if (rcnt > ready_dly) begin out_ready = 1'b1; ph = P_IDLE; end
        end
        default: begin
          checks++;
          if (iter_idx !== '0) begin
            errors++;
            $display("FAIL idle_idx: iter_idx=%0d required 0", iter_idx);
          end
          finished = 1;
        end
      endcase
      if (!finished) tick();
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL job_timeout: job not back in IDLE after %0d cycles", budget);
    end
    dp_ack = 1'b0; abort = 1'b0; out_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({start_ready, busy, out_valid, dp_load, dp_step, dir, iter_idx, rom_addr, shift_amt} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {AW{1'b0}}, {AW{1'b0}}, {AW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_state: rdy/busy/val/load/step/dir=%b idx=%0d required 100000 idx=0",
               {start_ready, busy, out_valid, dp_load, dp_step, dir}, iter_idx);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({start_ready, busy, out_valid, dp_load, dp_step} !== 5'b10000) begin
      errors++;
      $display("FAIL post_reset_idle: rdy/busy/val/load/step=%b required 10000",
               {start_ready, busy, out_valid, dp_load, dp_step});
    end
  endtask

  task automatic test_reset_mid_job();
    bit quiet;
    start_valid = 1'b1; mode = 1'b0;
    tick();
    start_valid = 1'b0; dp_ack = 1'b1;
    repeat (6) tick();
    dp_ack = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({start_ready, busy, out_valid, iter_idx} !== {1'b1, 1'b0, 1'b0, {AW{1'b0}}}) begin
      errors++;
      $display("FAIL mid_reset: rdy/busy/val=%b idx=%0d required 100 idx=0",
               {start_ready, busy, out_valid}, iter_idx);
    end
    quiet = 1;
    repeat (40) begin
      tick();
      if (out_valid || dp_step || dp_load || busy) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL mid_reset_quiet: activity seen after reset, required none");
    end
  endtask

  task automatic test_rotation();
    run_job(1'b0, 0, 1, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_vectoring();
    run_job(1'b1, 1, 3, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_ack_in_step();
    run_job(1'b0, 2, 2, 1'b1, -1, 0, 1'b0);
  endtask

  task automatic test_abort();
    run_job(1'b1, 2, 1, 1'b0, 7, 0, 1'b0);
    repeat (6) begin
      tick();
      checks++;
      if ({dp_load, dp_step, out_valid, busy, start_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL abort_quiet: load/step/valid/busy/ready=%b required 00001",
                 {dp_load, dp_step, out_valid, busy, start_ready});
      end
    end
  endtask

  task automatic test_done_hold();
    run_job(1'b0, 2, 1, 1'b0, -1, 5, 1'b0);
    run_job(1'b1, 2, 1, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job(1'b0, 1, 1, 1'b0, -1, 0, 1'b1);
    run_job(1'b1, 2, 2, 1'b0, -1, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_vectoring();
    test_ack_in_step();
    test_abort();
    test_done_hold();
    test_back_to_back();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
